// File: rtl/key_debouncer.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter FSM,
// registered level, press/release strobes and a wrapping press counter.
`timescale 1ns/1ps
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       r,
  input  logic       key_raw,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE,
    W_PRESS,
    HELD,
    W_REL
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic s1, s2;
  logic pressed;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, pp_n, rp_n;
  logic [7:0]       count_n;

  // Both flops reset to the released level so reset exit is never a press.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  assign pressed = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state         <= IDLE;
      cnt           <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      key_level     <= level_n;
      press_pulse   <= pp_n;
      release_pulse <= rp_n;
      press_count   <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = key_level;
    pp_n    = 1'b0;
    rp_n    = 1'b0;
    count_n = press_count;
    unique case (state)
      IDLE: begin
        level_n = 1'b0;
        if (pressed) begin
          state_n = W_PRESS;
          cnt_n   = ONE;
        end
      end
      W_PRESS: begin
        if (!pressed) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          pp_n    = 1'b1;
          level_n = 1'b1;
          count_n = press_count + 8'd1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      HELD: begin
        level_n = 1'b1;
        if (!pressed) begin
          state_n = W_REL;
          cnt_n   = ONE;
        end
      end
      W_REL: begin
        if (pressed) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          rp_n    = 1'b1;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised bench for key_debouncer: run-length reference model feeds
// an expectation queue drained by a negedge monitor.
`timescale 1ns/1ps
module tb_key_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       key_raw = 1'b1;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  key_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .r(r),
    .key_raw(key_raw),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .press_count(press_count)
  );

  typedef struct packed {
    logic       level;
    logic       press;
    logic       rel;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference: raw samples reach the debouncer two edges late; the level
  // flips once D consecutive samples disagree with it.
  logic       pipe[$];
  logic       m_level;
  logic       m_p;
  int         m_run;
  logic [7:0] m_cnt;
  int         m_press_tot = 0;
  int         m_rel_tot = 0;
  exp_t       me;

  always @(posedge clk or posedge r) begin
    me = '0;
    if (r) begin
      m_level = 1'b0;
      m_run   = 0;
      m_cnt   = 8'd0;
      pipe.delete();
      pipe.push_back(1'b1);
      pipe.push_back(1'b1);
      q.delete();
      q.push_back(me);
    end else begin
      m_p = (pipe[0] == 1'b0);
      void'(pipe.pop_front());
      pipe.push_back(key_raw);
      if (m_p != m_level) m_run++;
      else m_run = 0;
      if (m_run == D) begin
        m_level = !m_level;
        m_run   = 0;
        if (m_level) begin
          me.press = 1'b1;
          m_cnt++;
          m_press_tot++;
        end else begin
          me.rel = 1'b1;
          m_rel_tot++;
        end
      end
      me.level = m_level;
      me.cnt   = m_cnt;
      q.push_back(me);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  exp_t ce;
  logic prev_press = 1'b0;
  logic prev_rel = 1'b0;
  int   dut_press_tot = 0;
  int   dut_rel_tot = 0;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      ce = q.pop_front();
      chk("key_level", key_level, ce.level);
      chk("press_pulse", press_pulse, ce.press);
      chk("release_pulse", release_pulse, ce.rel);
      chk("press_count", press_count, ce.cnt);
    end
    chk("pulse_overlap", press_pulse & release_pulse, 0);
    chk("press_width", prev_press & press_pulse, 0);
    chk("release_width", prev_rel & release_pulse, 0);
    if (press_pulse) dut_press_tot++;
    if (release_pulse) dut_rel_tot++;
    prev_press = press_pulse;
    prev_rel   = release_pulse;
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      key_raw = v;
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #2;
    r = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    r = 1'b0;
  endtask

  task automatic bounce(input logic v);
    int k;
    k = $urandom_range(0, 3);
    repeat (k) begin
      drive(v, $urandom_range(1, D - 1));
      drive(!v, $urandom_range(1, D - 1));
    end
  endtask

  int p0, r0;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    r = 1'b0;
    drive(1'b1, 3);
    // clean press then clean release
    drive(1'b0, 12);
    drive(1'b1, 12);
    // short glitch
    drive(1'b0, 3);
    drive(1'b1, 10);
    // bounce then hold
    drive(1'b0, 1);
    drive(1'b1, 1);
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b0, 12);
    drive(1'b1, 12);
    // 256 press/release cycles with bounce
    pulse_reset(2);
    drive(1'b1, 3);
    @(negedge clk);
    #1;
    p0 = dut_press_tot;
    r0 = dut_rel_tot;
    repeat (256) begin
      bounce(1'b0);
      drive(1'b0, D + 3 + $urandom_range(0, 3));
      bounce(1'b1);
      drive(1'b1, D + 3 + $urandom_range(0, 3));
    end
    repeat (2) @(negedge clk);
    #1;
    chk("wrap_presses", dut_press_tot - p0, 256);
    chk("wrap_releases", dut_rel_tot - r0, 256);
    chk("wrap_count", press_count, 0);
    // reset while held, key kept down
    drive(1'b0, 12);
    r0 = dut_rel_tot;
    pulse_reset(3);
    drive(1'b0, 12);
    @(negedge clk);
    #1;
    chk("reset_no_release", dut_rel_tot - r0, 0);
    chk("reset_repress_level", key_level, 1);
    chk("reset_repress_count", press_count, 1);
    drive(1'b1, 12);
    // random run lengths
    repeat (80) drive(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    drive(1'b1, 12);
    repeat (2) @(negedge clk);
    #1;
    chk("press_total", dut_press_tot, m_press_tot);
    chk("release_total", dut_rel_tot, m_rel_tot);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
